// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues word requests over a req/ack
// handshake and holds each returned word for the decoder until it is accepted.
// Branch redirects that land while a request is outstanding are remembered via
// a kill flag so the stale word is dropped when it eventually returns.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus8
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD
  } state_t;

  state_t      state, state_nx;
  logic        kill, kill_nx;
  logic [31:0] fetch_pc, fetch_pc_nx;
  logic [31:0] req_addr, req_addr_nx;
  logic [31:0] instr_nx;
  logic [31:0] pc_nx;
  logic [31:0] target;

  // Word-aligned redirect address.
  assign target = branch_target & ~32'h0000_0003;

  // Outputs decoded purely from registered state.
  assign imem_req    = (state == S_REQ);
  assign imem_addr   = req_addr;
  assign instr_valid = (state == S_HOLD);
  assign pc_plus8    = pc + 32'd8;

  // State and datapath registers; async reset drops any outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      kill     <= 1'b0;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      instr    <= '0;
      pc       <= RESET_PC;
    end else begin
      state    <= state_nx;
      kill     <= kill_nx;
      fetch_pc <= fetch_pc_nx;
      req_addr <= req_addr_nx;
      instr    <= instr_nx;
      pc       <= pc_nx;
    end
  end

  // Next-state and datapath update. req_addr is loaded with the address of
  // the request about to be issued whenever S_REQ is (re)entered, so it stays
  // frozen while a request waits for its ack even if fetch_pc is redirected.
  always_comb begin
    state_nx    = state;
    kill_nx     = kill;
    fetch_pc_nx = fetch_pc;
    req_addr_nx = req_addr;
    instr_nx    = instr;
    pc_nx       = pc;
    case (state)
      S_IDLE: begin
        state_nx    = S_REQ;
        req_addr_nx = fetch_pc;
      end
      S_REQ: begin
        if (imem_ack) begin
          if (branch_taken) begin
            fetch_pc_nx = target;
            req_addr_nx = target;
            kill_nx     = 1'b0;
          end else if (kill) begin
            kill_nx     = 1'b0;
            req_addr_nx = fetch_pc;
          end else begin
            instr_nx    = imem_rdata;
            pc_nx       = req_addr;
            fetch_pc_nx = req_addr + 32'd4;
            state_nx    = S_HOLD;
          end
        end else if (branch_taken) begin
          fetch_pc_nx = target;
          kill_nx     = 1'b1;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          fetch_pc_nx = target;
          req_addr_nx = target;
          state_nx    = S_REQ;
        end else if (instr_ready) begin
          req_addr_nx = fetch_pc;
          state_nx    = S_REQ;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// run checked against a program-flow model (delivered PCs follow pc+4 or the
// last branch target, delivered words match the memory contents).
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus8;

  int checks = 0;
  int failures = 0;

  // Memory model controls
  int          fixed_lat = 0;
  bit          rand_lat = 1'b0;
  bit          force_ack = 1'b0;
  bit          pending = 1'b0;
  int          cnt = 0;
  logic [31:0] start_addr = '0;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .pc_plus8(pc_plus8)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hE081_1002;
  endfunction

  // Memory responder: answers each request after a latency, checks the
  // address does not move while the request is outstanding.
  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 1'b0;
      imem_ack = 1'b0;
    end else if (force_ack) begin
      pending = 1'b0;
      imem_ack = 1'b1;
      imem_rdata = memf(imem_addr);
    end else if (imem_req) begin
      if (!pending) begin
        pending = 1'b1;
        cnt = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
        start_addr = imem_addr;
      end else begin
        checks++;
        if (imem_addr !== start_addr) begin
          failures++;
          $display("FAIL addr_stable got=%h exp=%h", imem_addr, start_addr);
        end
      end
      if (cnt == 0) begin
        imem_ack = 1'b1;
        imem_rdata = memf(imem_addr);
        pending = 1'b0;
      end else begin
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        cnt--;
      end
    end else begin
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      pending = 1'b0;
    end
  end

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40 && instr_valid !== 1'b1; i++) @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout instr_valid=%b exp=1", tag, instr_valid);
    end
  endtask

  // From S_HOLD at a negedge: one-cycle branch; returns in S_REQ at the target.
  task automatic redirect(input logic [31:0] a);
    branch_taken = 1'b1;
    branch_target = a;
    @(negedge clk);
    branch_taken = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    instr_ready = 1'b0;
    branch_taken = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    checks++; if (instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", instr); end
    checks++; if (pc !== RST_PC) begin failures++; $display("FAIL rst_pc got=%h exp=%h", pc, RST_PC); end
    checks++; if (pc_plus8 !== RST_PC + 32'd8) begin failures++; $display("FAIL rst_pc8 got=%h exp=%h", pc_plus8, RST_PC + 32'd8); end
  endtask

  task automatic test_zero_wait;
    fixed_lat = 0;
    rand_lat = 1'b0;
    instr_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL zw_first_req req=%b addr=%h exp=1/0", imem_req, imem_addr); end
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL zw_valid got=%b exp=1", instr_valid); end
    checks++; if (instr !== 32'hE081_1002) begin failures++; $display("FAIL zw_instr got=%h exp=e0811002", instr); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL zw_pc got=%h exp=0", pc); end
    checks++; if (pc_plus8 !== 32'h8) begin failures++; $display("FAIL zw_pc8 got=%h exp=8", pc_plus8); end
    @(negedge clk);
    instr_ready = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin failures++; $display("FAIL zw_next_addr req=%b addr=%h exp=1/4", imem_req, imem_addr); end
  endtask

  task automatic test_delayed_ack;
    wait_valid("da_pre");
    fixed_lat = 3;
    redirect(32'h10);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL da_wait%0d req=%b addr=%h valid=%b exp=1/10/0", i, imem_req, imem_addr, instr_valid);
      end
      @(negedge clk);
    end
    checks++; if (instr_valid !== 1'b1 || pc !== 32'h10) begin failures++; $display("FAIL da_done valid=%b pc=%h exp=1/10", instr_valid, pc); end
    checks++; if (instr !== memf(32'h10)) begin failures++; $display("FAIL da_instr got=%h exp=%h", instr, memf(32'h10)); end
  endtask

  task automatic test_branch_inflight;
    fixed_lat = 3;
    redirect(32'h8);
    @(negedge clk);
    branch_taken = 1'b1;
    branch_target = 32'h203;
    @(negedge clk);
    branch_taken = 1'b0;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL bi_ack_cycle valid=%b exp=0", instr_valid); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || instr_valid !== 1'b0) begin failures++; $display("FAIL bi_new_req req=%b addr=%h valid=%b exp=1/200/0", imem_req, imem_addr, instr_valid); end
    wait_valid("bi");
    checks++; if (pc !== 32'h200) begin failures++; $display("FAIL bi_pc got=%h exp=200", pc); end
    checks++; if (instr !== memf(32'h200)) begin failures++; $display("FAIL bi_instr got=%h exp=%h", instr, memf(32'h200)); end
  endtask

  task automatic test_hold_stall;
    logic [31:0] held;
    fixed_lat = 0;
    redirect(32'h40);
    wait_valid("hs");
    checks++; if (pc !== 32'h40) begin failures++; $display("FAIL hs_pc got=%h exp=40", pc); end
    held = memf(32'h40);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr !== held || pc !== 32'h40) begin
        failures++;
        $display("FAIL hs_stable%0d valid=%b instr=%h pc=%h exp=1/%h/40", i, instr_valid, instr, pc, held);
      end
    end
    branch_taken = 1'b1;
    instr_ready = 1'b1;
    branch_target = 32'h100;
    @(negedge clk);
    branch_taken = 1'b0;
    instr_ready = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL hs_branch_req req=%b addr=%h exp=1/100", imem_req, imem_addr); end
    wait_valid("hs2");
    checks++; if (pc !== 32'h100) begin failures++; $display("FAIL hs_pc2 got=%h exp=100", pc); end
  endtask

  task automatic test_wrap;
    redirect(32'hFFFF_FFFC);
    wait_valid("wr");
    checks++; if (pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wr_pc got=%h exp=fffffffc", pc); end
    checks++; if (pc_plus8 !== 32'h4) begin failures++; $display("FAIL wr_pc8 got=%h exp=4", pc_plus8); end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL wr_next req=%b addr=%h exp=1/0", imem_req, imem_addr); end
    wait_valid("wr2");
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wr_pc2 got=%h exp=0", pc); end
  endtask

  task automatic test_reset_midreq;
    fixed_lat = 3;
    redirect(32'h80);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin failures++; $display("FAIL rm_pre req=%b addr=%h exp=1/80", imem_req, imem_addr); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL rm_async req=%b valid=%b exp=0/0", imem_req, instr_valid); end
    checks++; if (instr !== 32'h0 || pc !== RST_PC || pc_plus8 !== RST_PC + 32'd8) begin failures++; $display("FAIL rm_regs instr=%h pc=%h pc8=%h exp=0/%h/%h", instr, pc, pc_plus8, RST_PC, RST_PC + 32'd8); end
    @(negedge clk);
    force_ack = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC || instr_valid !== 1'b0) begin failures++; $display("FAIL rm_first_req req=%b addr=%h valid=%b exp=1/%h/0", imem_req, imem_addr, instr_valid, RST_PC); end
    @(negedge clk);
    force_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1 || pc !== RST_PC || instr !== memf(RST_PC)) begin failures++; $display("FAIL rm_refetch valid=%b pc=%h instr=%h exp=1/%h/%h", instr_valid, pc, instr, RST_PC, memf(RST_PC)); end
  endtask

  task automatic test_random;
    logic [31:0] exp_pc, prev_pc, prev_instr, prev_tgt;
    bit prev_vld, prev_rdy, prev_br;
    int deliveries, quiet;
    rst_n = 1'b0;
    instr_ready = 1'b0;
    branch_taken = 1'b0;
    rand_lat = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = RST_PC;
    prev_vld = 0; prev_rdy = 0; prev_br = 0;
    prev_pc = '0; prev_instr = '0; prev_tgt = '0;
    deliveries = 0;
    quiet = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (prev_br) exp_pc = prev_tgt & ~32'h3;
      if (prev_vld) begin
        checks++;
        if (!prev_rdy && !prev_br) begin
          if (instr_valid !== 1'b1 || instr !== prev_instr || pc !== prev_pc) begin
            failures++;
            $display("FAIL rnd_hold n=%0d valid=%b instr=%h pc=%h exp=1/%h/%h", n, instr_valid, instr, pc, prev_instr, prev_pc);
          end
        end else if (instr_valid !== 1'b0) begin
          failures++;
          $display("FAIL rnd_consume n=%0d valid=%b exp=0", n, instr_valid);
        end
      end else if (instr_valid === 1'b1) begin
        checks++;
        if (pc !== exp_pc || instr !== memf(exp_pc)) begin
          failures++;
          $display("FAIL rnd_deliver n=%0d pc=%h instr=%h exp=%h/%h", n, pc, instr, exp_pc, memf(exp_pc));
        end
        exp_pc = pc + 32'd4;
        deliveries++;
      end
      checks++;
      if (pc_plus8 !== pc + 32'd8 || imem_addr[1:0] !== 2'b00 || (instr_valid && imem_req)) begin
        failures++;
        $display("FAIL rnd_misc n=%0d pc8=%h pc=%h addr=%h valid=%b req=%b", n, pc_plus8, pc, imem_addr, instr_valid, imem_req);
      end
      quiet = instr_valid ? 0 : quiet + 1;
      if (quiet > 60) begin
        checks++;
        failures++;
        $display("FAIL rnd_watchdog n=%0d no delivery for %0d cycles", n, quiet);
        break;
      end
      prev_vld = instr_valid;
      prev_pc = pc;
      prev_instr = instr;
      instr_ready = ($urandom_range(0, 9) < 6);
      branch_taken = ($urandom_range(0, 15) == 0);
      branch_target = $urandom;
      if ($urandom_range(0, 3) == 0) branch_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      prev_rdy = instr_ready;
      prev_br = branch_taken;
      prev_tgt = branch_target;
    end
    branch_taken = 1'b0;
    instr_ready = 1'b0;
    checks++;
    if (deliveries < 100) begin
      failures++;
      $display("FAIL rnd_deliveries got=%0d exp>=100", deliveries);
    end
  endtask

  initial begin
    test_reset;
    test_zero_wait;
    test_delayed_ack;
    test_branch_inflight;
    test_hold_stall;
    test_wrap;
    test_reset_midreq;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
